alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU with a valid/ready handshake, full status flags (C, V, Z, N) and iterative multi-cycle shift/rotate and optional multiply. It serves as the execution unit of the RISC datapath.
- Single-cycle arithmetic and logic ops keep the existing 3-bit-select-plus-carry-in encoding.
- A fourth select bit opens a multi-cycle op space sequenced by an internal FSM.

## Interface
- `BITS`, 16: datapath width. Must be a power of two, ≥ 4. Local `SHW = clog2(BITS)`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block accepts a request this cycle.
- `Sel` in 4: op select. `Sel[3]=0` selects the single-cycle table; `Sel[3]=1` selects the multi-cycle table.
- `Cin` in 1: carry in.
- `A`, `B` in BITS: operands.
- `out_valid` out 1: result registers hold a result.
- `out_ready` in 1: consumer takes the result.
- `Out` out BITS: result.
- `Cout` out 1: carry out, or last bit shifted out.
- `statV` out 1: signed overflow.
- `statZ` out 1: `Out == 0`.
- `statN` out 1: `Out[BITS-1]`.
- `busy` out 1: FSM is not in `IDLE`.

## Operation
- Accept occurs when `in_valid && in_ready`. `A`, `B`, `Sel` and `Cin` are captured at accept and ignored afterwards.
- Single-cycle table, keyed on `{Sel[2:0],Cin}`:
  - `0000` transfer A
  - `0001` A+1
  - `0010` A+B
  - `0011` A+B+1
  - `0100` A+~B
  - `0101` A+~B+1
  - `0110` A−1, computed as A + all-ones
  - `0111` transfer A
  - `100x` AND
  - `101x` OR
  - `110x` XOR
  - `111x` NOT A
- Arithmetic rules:
  - Arithmetic is computed at BITS+1 width. `Cout` is bit BITS of that result.
  - `statV` = (a_msb == b_eff_msb) && (res_msb != a_msb), where b_eff is the effective second addend (B, ~B, all-ones or 0).
  - Transfer and logic ops set `Cout` = 0 and `statV` = 0.
- Multi-cycle table, keyed on `Sel[2:0]`, with shift amount k = `B[SHW-1:0]`:
  - `000` SLL
  - `001` SRL
  - `010` SRA
  - `011` ROL
  - `100` ROR
  - `101` MUL (see Configuration)
  - `110`/`111` reserved: Out = A, `Cout` = 0, `statV` = 0, single cycle.
- Shifts and rotates move one bit position per cycle. `Cout` is the last bit shifted or rotated out; it is 0 when k = 0. `statV` = 0. `Cin` is ignored.
- `statZ` and `statN` are always derived from the registered `Out`.
- FSM states:
  - `IDLE`: on accept, a single-cycle op, reserved op or k = 0 goes to `DONE` with the result registered. A shift with k ≥ 1 goes to `SHIFT`. MUL goes to `MUL`.
  - `SHIFT`: decrement the counter each cycle; go to `DONE` when it reaches 0.
  - `MUL`: shift-add iteration over BITS cycles, then go to `DONE`.
  - `DONE`: `out_valid` = 1. On `out_ready`, go to `IDLE`.
- `in_ready` = (state == `IDLE`). No new request is accepted while a result is unconsumed.

## Timing
- Reset values: `Out` = 0, `Cout` = 0, all `stat*` = 0, `out_valid` = 0, `busy` = 0, state = `IDLE`, `in_ready` = 1.
- Single-cycle op: `out_valid` rises 1 cycle after accept.
- Shift with k ≥ 1: `out_valid` rises k+1 cycles after accept.
- MUL: `out_valid` rises BITS+1 cycles after accept.
- While `out_valid && !out_ready`: `Out` and all flags hold stable and `in_ready` = 0.
- The cycle `out_ready` is sampled high: `out_valid` drops on the next edge and `in_ready` returns to 1 on that edge. There is no same-cycle accept/consume overlap.
- Reset asserted mid-operation aborts immediately. No `out_valid` is produced and all outputs take their reset values.
- `in_valid` while `busy`: ignored and not queued.

## Configuration
- `ALU_SEQ_MUL_EN` defined: `Sel = 1101` runs an unsigned iterative multiply.
  - `Out` = low BITS bits of A·B.
  - `Cout` = `statV` = OR of the high BITS bits of the product.
- `ALU_SEQ_MUL_EN` undefined: `Sel = 1101` behaves as a reserved op. No multiplier state or adder path is synthesised.

## Test plan
All scenarios use BITS = 16.
- `Sel=0001`, `Cin=0`, A=0x7FFF, B=0x0001 (A+B) -> Out 0x8000, V=1, N=1, C=0, Z=0, `out_valid` 1 cycle after accept.
- `Sel=0010`, `Cin=1`, A=5, B=7 (subtract) -> Out 0xFFFE, C=0, N=1, V=0. Then `0011` with A=0x8000 -> Out 0x7FFF, C=1, V=1.
- `Sel=1010`, A=0x8001, B=4 (SRA) -> Out 0xF800, C=0, `out_valid` 5 cycles after accept. `Sel=1011`, A=0x8001, B=1 (ROL) -> Out 0x0003, C=1.
- `out_ready` held low for 3 cycles after a result -> Out and flags stable, `in_ready` = 0, a pulsed `in_valid` is ignored. Release -> `in_ready` = 1 on the next edge.
- `rst_n` low during `SHIFT` (A=0xFFFF, B=15, 3 cycles in) -> all outputs 0 at once, no `out_valid` after release, next op executes normally.
- `ALU_SEQ_MUL_EN` defined: A=0x0100, B=0x0100 -> Out 0x0000, C=1, V=1, Z=1 after 17 cycles. Undefined: same stimulus -> Out 0x0100, C=0, 1-cycle latency.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, C/V/Z/N flags and iterative shift/rotate.
// Define ALU_SEQ_MUL_EN to build the iterative unsigned multiply on Sel=1101.
module alu_seq #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      Sel,
  input  logic            Cin,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] Out,
  output logic            Cout,
  output logic            statV,
  output logic            statZ,
  output logic            statN,
  output logic            busy
);
  localparam int SHW = $clog2(BITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] MUL   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [BITS-1:0] out_q, out_d, work_q, work_d;
  logic            c_q, c_d, v_q, v_d, z_q, z_d;
  logic [2:0]      op_q, op_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
`ifdef ALU_SEQ_MUL_EN
  logic [BITS-1:0] mhi_q, mhi_d, mlo_q, mlo_d;
  logic [BITS:0]   madd;
`endif

  // single-cycle table
  logic [BITS-1:0] sc_b, sc_l, sc_res;
  logic            sc_ci, sc_ar, sc_c, sc_v;
  logic [BITS:0]   sc_sum;

  always_comb begin
    sc_b  = '0;
    sc_ci = 1'b0;
    sc_ar = 1'b0;
    sc_l  = A;
    case ({Sel[2:0], Cin})
      4'b0001: begin sc_ar = 1'b1; sc_ci = 1'b1; end
      4'b0010: begin sc_ar = 1'b1; sc_b = B; end
      4'b0011: begin sc_ar = 1'b1; sc_b = B; sc_ci = 1'b1; end
      4'b0100: begin sc_ar = 1'b1; sc_b = ~B; end
      4'b0101: begin sc_ar = 1'b1; sc_b = ~B; sc_ci = 1'b1; end
      4'b0110: begin sc_ar = 1'b1; sc_b = '1; end
      4'b1000, 4'b1001: sc_l = A & B;
      4'b1010, 4'b1011: sc_l = A | B;
      4'b1100, 4'b1101: sc_l = A ^ B;
      4'b1110, 4'b1111: sc_l = ~A;
      default: sc_l = A;
    endcase
    sc_sum = {1'b0, A} + {1'b0, sc_b} + {{BITS{1'b0}}, sc_ci};
    sc_res = sc_ar ? sc_sum[BITS-1:0] : sc_l;
    sc_c   = sc_ar & sc_sum[BITS];
    sc_v   = sc_ar & (A[BITS-1] == sc_b[BITS-1]) & (sc_sum[BITS-1] != A[BITS-1]);
  end

  // one bit position per cycle; sh_bit is the bit leaving the word
  logic [BITS-1:0] sh_res;
  logic            sh_bit;

  always_comb begin
    sh_res = work_q;
    sh_bit = 1'b0;
    case (op_q)
      3'd0: begin sh_res = {work_q[BITS-2:0], 1'b0};         sh_bit = work_q[BITS-1]; end
      3'd1: begin sh_res = {1'b0, work_q[BITS-1:1]};         sh_bit = work_q[0]; end
      3'd2: begin sh_res = {work_q[BITS-1], work_q[BITS-1:1]}; sh_bit = work_q[0]; end
      3'd3: begin sh_res = {work_q[BITS-2:0], work_q[BITS-1]}; sh_bit = work_q[BITS-1]; end
      3'd4: begin sh_res = {work_q[0], work_q[BITS-1:1]};    sh_bit = work_q[0]; end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // work_q holds the multiplicand; {mhi,mlo} is the product/multiplier pair
  assign madd = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, work_q} : {(BITS+1){1'b0}});
`endif

  logic [BITS-1:0] res;
  logic            res_c, res_v, load;
  logic [SHW-1:0]  k;

  assign k = B[SHW-1:0];

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    load    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mhi_d   = mhi_q;
    mlo_d   = mlo_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        op_d   = Sel[2:0];
        work_d = A;
        if (!Sel[3]) begin
          res = sc_res; res_c = sc_c; res_v = sc_v; load = 1'b1;
          state_d = DONE;
        end else if (Sel[2:0] <= 3'd4 && k != '0) begin
          cnt_d   = k - {{(SHW-1){1'b0}}, 1'b1};
          state_d = SHIFT;
`ifdef ALU_SEQ_MUL_EN
        end else if (Sel[2:0] == 3'd5) begin
          cnt_d   = '1;
          mhi_d   = '0;
          mlo_d   = B;
          state_d = MUL;
`endif
        end else begin
          // reserved ops and zero-length shifts pass A through
          res = A; load = 1'b1;
          state_d = DONE;
        end
      end
      SHIFT: begin
        work_d = sh_res;
        cnt_d  = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == '0) begin
          res = sh_res; res_c = sh_bit; load = 1'b1;
          state_d = DONE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        mhi_d = madd[BITS:1];
        mlo_d = {madd[0], mlo_q[BITS-1:1]};
        cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == '0) begin
          res = {madd[0], mlo_q[BITS-1:1]}; res_c = |madd[BITS:1]; res_v = |madd[BITS:1];
          load = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      out_d = res;
      c_d   = res_c;
      v_d   = res_v;
      z_d   = (res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mhi_q   <= '0;
      mlo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
`ifdef ALU_SEQ_MUL_EN
      mhi_q   <= mhi_d;
      mlo_q   <= mlo_d;
`endif
    end
  end

  assign Out       = out_q;
  assign Cout      = c_q;
  assign statV     = v_q;
  assign statZ     = z_q;
  assign statN     = out_q[BITS-1];
  assign out_valid = (state_q == DONE);
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: spec-level model, per-cycle compare process, literal pins.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  Sel = '0;
  logic        Cin = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Out;
  logic        Cout, statV, statZ, statN, busy;

  alu_seq #(.BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Sel(Sel), .Cin(Cin), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .Cout(Cout), .statV(statV), .statZ(statZ), .statN(statN), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result from the op rules, using plain integer arithmetic.
  task automatic model(input logic [3:0] s, input logic ci, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] o, output logic c, output logic v, output int lat);
    int k;
    logic [15:0] be;
    int unsigned us;
    int signed ts;
    logic [31:0] p;
    o = a; c = 1'b0; v = 1'b0; lat = 1;
    k = int'(b[3:0]);
    if (!s[3]) begin
      if (s[2]) begin
        case (s[1:0])
          2'd0: o = a & b;
          2'd1: o = a | b;
          2'd2: o = a ^ b;
          default: o = ~a;
        endcase
      end else if (!({s[1:0], ci} == 3'b000 || {s[1:0], ci} == 3'b111)) begin
        case (s[1:0])
          2'd0: be = 16'h0000;
          2'd1: be = b;
          2'd2: be = ~b;
          default: be = 16'hFFFF;
        endcase
        us = 32'(a) + 32'(be) + 32'(ci);
        ts = int'($signed(a)) + int'($signed(be)) + int'(ci);
        o = us[15:0];
        c = (us > 32'd65535);
        v = (ts > 32767) || (ts < -32768);
      end
    end else begin
      case (s[2:0])
        3'd0: begin o = a << k; c = (k != 0) ? a[16-k] : 1'b0; end
        3'd1: begin o = a >> k; c = (k != 0) ? a[k-1] : 1'b0; end
        3'd2: begin o = $signed(a) >>> k; c = (k != 0) ? a[k-1] : 1'b0; end
        3'd3: begin o = (a << k) | (a >> (16 - k)); c = (k != 0) ? o[0] : 1'b0; end
        3'd4: begin o = (a >> k) | (a << (16 - k)); c = (k != 0) ? o[15] : 1'b0; end
`ifdef ALU_SEQ_MUL_EN
        3'd5: begin p = 32'(a) * 32'(b); o = p[15:0]; c = |p[31:16]; v = c; lat = 17; end
`endif
        default: o = a;
      endcase
      if (s[2:0] <= 3'd4 && k != 0) lat = k + 1;
    end
  endtask

  logic [15:0] exp_o;
  logic        exp_c, exp_v;
  int          exp_lat;
  bit          has_exp = 0;
  bit          seen = 0;
  int          acc_cyc = 0;

  // Compare process: every out-of-reset cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_busy", 32'(in_ready), 32'(!busy));
      if (out_valid) begin
        if (!has_exp) chk("spurious_valid", 32'(out_valid), 32'd0);
        else begin
          chk("out", 32'(Out), 32'(exp_o));
          chk("cout", 32'(Cout), 32'(exp_c));
          chk("statV", 32'(statV), 32'(exp_v));
          chk("statZ", 32'(statZ), 32'(exp_o == 16'h0));
          chk("statN", 32'(statN), 32'(exp_o[15]));
          if (!seen) begin
            chk("latency", 32'(cyc - acc_cyc + 1), 32'(exp_lat));
            seen = 1;
          end
        end
      end
    end
  end

  task automatic run_op(input logic [3:0] s, input logic ci, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit use_lit, input logic [15:0] lo, input logic lc,
                        input logic lv);
    int n;
    logic [15:0] mo;
    logic mc, mv;
    int ml;
    @(negedge clk);
    chk("ready_pre", 32'(in_ready), 32'd1);
    model(s, ci, a, b, mo, mc, mv, ml);
    exp_o = mo; exp_c = mc; exp_v = mv; exp_lat = ml;
    seen = 0; has_exp = 1; acc_cyc = cyc + 1;
    Sel = s; Cin = ci; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'hDEAD; B = 16'hBEEF;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
    if (use_lit) begin
      chk("lit_out", 32'(Out), 32'(lo));
      chk("lit_cout", 32'(Cout), 32'(lc));
      chk("lit_v", 32'(statV), 32'(lv));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ready", 32'(in_ready), 32'd0);
      in_valid = (i == 1);
      Sel = 4'b0010; Cin = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    has_exp = 0;
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_out", 32'(Out), 32'd0);
    chk("rst_flags", 32'({Cout, statV, statZ, statN}), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0001, 1'b0, 16'h7FFF, 16'h0001, 0, 1, 16'h8000, 1'b0, 1'b1);
    run_op(4'b0010, 1'b1, 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 1'b0, 1'b0);
    run_op(4'b0011, 1'b0, 16'h8000, 16'h0000, 0, 1, 16'h7FFF, 1'b1, 1'b1);
    run_op(4'b0010, 1'b1, 16'h0005, 16'h0005, 0, 1, 16'h0000, 1'b1, 1'b0);
    run_op(4'b0000, 1'b1, 16'h1234, 16'h0000, 0, 1, 16'h1235, 1'b0, 1'b0);
    run_op(4'b0010, 1'b0, 16'h0003, 16'h0001, 0, 1, 16'h0001, 1'b1, 1'b0);
    run_op(4'b0000, 1'b0, 16'hA5A5, 16'h1111, 0, 1, 16'hA5A5, 1'b0, 1'b0);
    run_op(4'b0011, 1'b1, 16'h5A5A, 16'h1111, 0, 1, 16'h5A5A, 1'b0, 1'b0);
    run_op(4'b0100, 1'b0, 16'hF0F0, 16'hFF00, 0, 1, 16'hF000, 1'b0, 1'b0);
    run_op(4'b0101, 1'b1, 16'hF0F0, 16'h0F00, 0, 1, 16'hFFF0, 1'b0, 1'b0);
    run_op(4'b0110, 1'b0, 16'hF0F0, 16'hFF00, 0, 0, 16'h0, 1'b0, 1'b0);
    run_op(4'b0111, 1'b0, 16'h00FF, 16'h0000, 0, 1, 16'hFF00, 1'b0, 1'b0);
    run_op(4'b1010, 1'b0, 16'h8001, 16'h0004, 3, 1, 16'hF800, 1'b0, 1'b0);
    run_op(4'b1011, 1'b0, 16'h8001, 16'h0001, 0, 1, 16'h0003, 1'b1, 1'b0);
    run_op(4'b1000, 1'b0, 16'h8001, 16'h0001, 0, 1, 16'h0002, 1'b1, 1'b0);
    run_op(4'b1000, 1'b1, 16'h0001, 16'h000F, 0, 1, 16'h8000, 1'b0, 1'b0);
    run_op(4'b1001, 1'b0, 16'h0003, 16'h0001, 0, 1, 16'h0001, 1'b1, 1'b0);
    run_op(4'b1001, 1'b0, 16'h0003, 16'h0000, 0, 1, 16'h0003, 1'b0, 1'b0);
    run_op(4'b1100, 1'b0, 16'h0001, 16'h0001, 0, 1, 16'h8000, 1'b1, 1'b0);
    run_op(4'b1100, 1'b0, 16'h1234, 16'h0008, 2, 0, 16'h0, 1'b0, 1'b0);
    run_op(4'b1110, 1'b1, 16'h4321, 16'h0005, 0, 1, 16'h4321, 1'b0, 1'b0);
    run_op(4'b1111, 1'b0, 16'h0000, 16'h0005, 0, 1, 16'h0000, 1'b0, 1'b0);
`ifdef ALU_SEQ_MUL_EN
    run_op(4'b1101, 1'b0, 16'h0100, 16'h0100, 0, 1, 16'h0000, 1'b1, 1'b1);
    run_op(4'b1101, 1'b0, 16'h0003, 16'h0005, 0, 1, 16'h000F, 1'b0, 1'b0);
`else
    run_op(4'b1101, 1'b0, 16'h0100, 16'h0100, 0, 1, 16'h0100, 1'b0, 1'b0);
`endif

    // reset in the middle of a long shift
    @(negedge clk);
    has_exp = 0;
    Sel = 4'b1000; Cin = 1'b0; A = 16'hFFFF; B = 16'h000F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_in_shift", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out", 32'(Out), 32'd0);
    chk("abort_flags", 32'({Cout, statV, statZ, statN}), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    run_op(4'b0001, 1'b0, 16'h1234, 16'h1111, 0, 1, 16'h2345, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
